// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor helper and
// legal bounds for the frame-shape parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Divisor rounded to nearest so the bit period error stays within half a clock.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// DIV-cycle bit timer: counts while running, emits a one-cycle tick on the
// last cycle of each bit period; cleared when a frame starts.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear || o_tick)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-word holding register for
// back-to-back frames. Optional parity bit enabled by UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 txEn,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 txBusy,
    output logic                 txReady,
    output logic                 txDone
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        DIV < 4 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_tx_frame: illegal parameter set");
    end

    uart_state_e          r_state, w_next;
    logic [DATA_BITS-1:0] r_hold, r_shift;
    logic                 r_hold_full, r_done;
    logic [3:0]           r_bitcnt;
    logic                 w_tick, w_load, w_frame_end, w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_load),
        .i_run  (txBusy),
        .o_tick (w_tick)
    );

    assign txBusy   = (r_state != IDLE);
    // A load on this edge frees the holding register, so a new word may land in it.
    assign txReady  = !r_hold_full || w_load;
    assign w_accept = txStart && txEn && txReady;
    assign txDone   = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: if (r_hold_full && txEn) begin
                w_next = START;
                w_load = 1'b1;
            end
            START: if (w_tick) w_next = DATA;
            DATA: if (w_tick && r_bitcnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                w_next = PARITY;
`else
                w_next = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) w_next = STOP;
`endif
            STOP: if (w_tick && r_bitcnt == LAST_STOP) begin
                w_frame_end = 1'b1;
                if (r_hold_full && txEn) begin
                    w_next = START;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            START:  tx = 1'b0;
            DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx = r_parity;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_done <= w_frame_end;
            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load)
                r_shift <= r_hold;
            else if (w_tick && r_state == DATA)
                r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
            if (w_load)
                r_parity <= (^r_hold) ^ 1'(PARITY_ODD);
`endif
            // Bit index restarts whenever the FSM moves to a new phase.
            if (w_tick)
                r_bitcnt <= (w_next == r_state) ? r_bitcnt + 4'd1 : 4'd0;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations (8N1 even, 7N2 odd) checked every
// cycle against a frame-position model, plus literal frame expectations.
module tb_uart_tx_frame;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DB[2]   = '{8, 7};
    localparam int SB[2]   = '{1, 2};
    localparam int PODD[2] = '{0, 1};
    localparam int NB[2]   = '{1 + 8 + P + 1, 1 + 7 + P + 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en = '0, st = '0;
    logic [8:0] din[2];
    wire  [1:0] tx, busy, rdy, dn;

    int  n_chk = 0, n_err = 0, cyc = 0;
    bit  chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                    .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .txEn(en[0]), .txStart(st[0]), .in_data(din[0][7:0]),
        .tx(tx[0]), .txBusy(busy[0]), .txReady(rdy[0]), .txDone(dn[0]));

    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7),
                    .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .txEn(en[1]), .txStart(st[1]), .in_data(din[1][6:0]),
        .tx(tx[1]), .txBusy(busy[1]), .txReady(rdy[1]), .txDone(dn[1]));

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc=%0d got=%b exp=%b", name, i, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Value of frame bit idx: start, data LSB first, optional parity, stops.
    function automatic logic fbit(input int db, input int podd, input logic [8:0] d, input int idx);
        logic [8:0] m;
        m = 9'((1 << db) - 1);
        if (idx == 0) return 1'b0;
        if (idx <= db) return d[idx-1];
        if (P == 1 && idx == db + 1) return (^(d & m)) ^ podd[0];
        return 1'b1;
    endfunction

    // Reference model: a frame is a cycle position 0..N*DIV-1 over a word.
    bit         m_act[2], m_full[2], m_done[2];
    int         m_pos[2];
    logic [8:0] m_frame[2], m_hold[2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            bit last, load, ready, acc;
            last  = m_act[i] && (m_pos[i] == NB[i] * DIV - 1);
            load  = m_full[i] && en[i] && (!m_act[i] || last);
            ready = !m_full[i] || load;
            acc   = st[i] && en[i] && ready;
            if (!rst_n) begin
                m_act[i] <= 1'b0; m_full[i] <= 1'b0; m_done[i] <= 1'b0; m_pos[i] <= 0;
            end else begin
                m_done[i] <= last;
                if (load) begin
                    m_act[i] <= 1'b1; m_pos[i] <= 0; m_frame[i] <= m_hold[i];
                end else if (last) begin
                    m_act[i] <= 1'b0;
                end else if (m_act[i]) begin
                    m_pos[i] <= m_pos[i] + 1;
                end
                if (acc) begin
                    m_hold[i] <= din[i] & 9'((1 << DB[i]) - 1); m_full[i] <= 1'b1;
                end else if (load) begin
                    m_full[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                logic e_tx, e_rdy;
                e_tx  = m_act[i] ? fbit(DB[i], PODD[i], m_frame[i], m_pos[i] / DIV) : 1'b1;
                e_rdy = !m_full[i] || (en[i] && (!m_act[i] || m_pos[i] == NB[i] * DIV - 1));
                chk("tx", i, tx[i], e_tx);
                chk("txBusy", i, busy[i], m_act[i]);
                chk("txReady", i, rdy[i], e_rdy);
                chk("txDone", i, dn[i], m_done[i]);
            end
        end
    end

    // Send one word from idle and pin bit values, done cycle and busy length.
    task automatic frame_lit(input int i, input logic [8:0] d, input logic [11:0] bits,
                             input int exp_done);
        int busy_cnt, done_at;
        busy_cnt = 0; done_at = -1;
        en[i] = 1'b1; din[i] = d; st[i] = 1'b1;
        @(posedge clk); #2 st[i] = 1'b0;
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(posedge clk); #2;
            if (busy[i]) busy_cnt++;
            if (dn[i] && done_at < 0) done_at = c;
            if ((c - 1) % DIV == DIV / 2 && (c - 1) / DIV < NB[i])
                chk("lit_bit", i, tx[i], bits[(c - 1) / DIV]);
        end
        chk_int("lit_done_cycle", done_at, exp_done);
        chk_int("lit_busy_cycles", busy_cnt, NB[i] * DIV);
    endtask

    initial begin
        int nl0, t1, t2, dcount, drop;
        din[0] = '0; din[1] = '0;
        nl0 = NB[0] * DIV;
        @(posedge clk); chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", i, tx[i], 1'b1);
            chk("rst_busy", i, busy[i], 1'b0);
            chk("rst_ready", i, rdy[i], 1'b1);
            chk("rst_done", i, dn[i], 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #2;

`ifdef UART_TX_PARITY_EN
        frame_lit(0, 9'h096, 12'h52C, 111);
        frame_lit(1, 9'h07F, 12'h6FE, 111);
`else
        frame_lit(0, 9'h096, 12'h32C, 101);
        frame_lit(1, 9'h07F, 12'h3FE, 101);
`endif

        // Back-to-back pair with a third word offered while the holding register is full.
        en[0] = 1'b1; din[0] = 9'h055; st[0] = 1'b1;
        @(posedge clk); #2 st[0] = 1'b0;
        t1 = 0; t2 = 0; dcount = 0; drop = 0;
        for (int c = 1; c <= 3 * nl0 + 20; c++) begin
            @(posedge clk); #2;
            if (c == 30) begin din[0] = 9'h0A3; st[0] = 1'b1; end
            if (c == 31) begin st[0] = 1'b0; chk("b2b_ready_low", 0, rdy[0], 1'b0); end
            if (c == 50) begin din[0] = 9'h0FF; st[0] = 1'b1; end
            if (c == 51) st[0] = 1'b0;
            if (dn[0]) begin
                dcount++;
                if (dcount == 1) t1 = c; else if (dcount == 2) t2 = c;
            end
            if (c <= 2 * nl0 && !busy[0]) drop = 1;
        end
        chk_int("b2b_done1", t1, nl0 + 1);
        chk_int("b2b_done2", t2, 2 * nl0 + 1);
        chk_int("b2b_frames", dcount, 2);
        chk_int("b2b_busy_drop", drop, 0);

        // txEn low: strobes ignored; dropping mid-frame leaves the held word waiting.
        en[0] = 1'b0; din[0] = 9'h03C; st[0] = 1'b1;
        repeat (5) @(posedge clk);
        #2 st[0] = 1'b0;
        chk("en0_busy", 0, busy[0], 1'b0);
        chk("en0_tx", 0, tx[0], 1'b1);
        en[0] = 1'b1; din[0] = 9'h011; st[0] = 1'b1;
        @(posedge clk); #2 st[0] = 1'b0;
        for (int c = 1; c <= nl0 + 60; c++) begin
            @(posedge clk); #2;
            if (c == 20) begin din[0] = 9'h022; st[0] = 1'b1; end
            if (c == 21) st[0] = 1'b0;
            if (c == 30) en[0] = 1'b0;
        end
        chk("en_held_busy", 0, busy[0], 1'b0);
        chk("en_held_tx", 0, tx[0], 1'b1);
        chk("en_held_ready", 0, rdy[0], 1'b0);
        en[0] = 1'b1;
        @(posedge clk); #2;
        chk("en_resume_busy", 0, busy[0], 1'b1);
        chk("en_resume_ready", 0, rdy[0], 1'b1);
        repeat (nl0 + 5) @(posedge clk);
        #2;

        // Reset 35 cycles into a 7N2 frame.
        en[1] = 1'b1; din[1] = 9'h07F; st[1] = 1'b1;
        @(posedge clk); #2 st[1] = 1'b0;
        repeat (35) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        chk("mid_rst_tx", 1, tx[1], 1'b1);
        chk("mid_rst_busy", 1, busy[1], 1'b0);
        chk("mid_rst_ready", 1, rdy[1], 1'b1);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk); #2;
            if (dn[1]) dcount++;
        end
        chk_int("mid_rst_no_done", dcount, 0);

        // Randomised traffic on both configurations.
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < 2; i++) begin
                st[i]  = ($urandom_range(0, 7) == 0);
                din[i] = 9'($urandom);
                if ($urandom_range(0, 59) == 0) en[i] = ~en[i];
                if (!en[i] && $urandom_range(0, 9) == 0) en[i] = 1'b1;
            end
            rst_n = ($urandom_range(0, 2999) != 0);
        end
        rst_n = 1'b1; st = '0;
        repeat (5) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
